lap_store: RTL and testbench

//  Responder to the stopwatch control FSM's one-hot state vector: records lap

---
 rtl/lap_store_pkg.sv | 27 ++
 rtl/stopwatch_pkg.sv | 21 ++
 rtl/lap_store_if.sv | 31 +++
 rtl/lap_ram.sv | 32 +++
 rtl/lap_store.sv | 125 ++++++++++++
 tb/tb_lap_store.sv | 209 ++++++++++++++++++++
 6 files changed

// File: rtl/lap_store_pkg.sv
// lap_store_pkg
//   Local types and defaults of the lap store.
//   LAP_DEPTH / LAP_PTR_W : default number of lap entries and its log2
//   lap_fsm_e             : internal controller states
//   cmd_legal()           : whether a control state vector may start an action
package lap_store_pkg;
  import stopwatch_pkg::*;

  localparam int LAP_DEPTH = 8;
  localparam int LAP_PTR_W = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WIPE = 1'b1
  } lap_fsm_e;

  // A proper one-hot vector is legal. The one two-hot pattern RESET+RETRIEVE
  // is also accepted so that a RESET entry colliding with a RETRIEVE entry
  // still wipes; any other multi-bit or empty vector starts nothing.
  function automatic logic cmd_legal(input logic [STATE_W-1:0] s);
    logic [STATE_W-1:0] pair;
    pair           = '0;
    pair[RESET]    = 1'b1;
    pair[RETRIEVE] = 1'b1;
    return $onehot(s) || (s == pair);
  endfunction
endpackage

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg
//   Definitions shared by the stopwatch control FSM and its responder blocks.
//   STATE_W : width of the one-hot control state vector
//   TIME_W  : width of a timestamp (6 BCD digits mm:ss:cc)
//   IDLE..CLEAR : bit index of each control state inside the one-hot vector
package stopwatch_pkg;
  localparam int STATE_W  = 11;
  localparam int TIME_W   = 24;

  localparam int IDLE     = 0;
  localparam int ARMED    = 1;
  localparam int RUNNING  = 2;
  localparam int PAUSED   = 3;
  localparam int LAP      = 4;
  localparam int RETRIEVE = 5;
  localparam int DISPLAY  = 6;
  localparam int SCROLL   = 7;
  localparam int RESET    = 8;
  localparam int DONE     = 9;
  localparam int CLEAR    = 10;
endpackage

// File: rtl/lap_store_if.sv
// lap_store_if
//   Bundle between the stopwatch control/LCD side (master) and the lap
//   store (slave).
//   state     : one-hot control state            (master -> slave)
//   time_now  : live stopwatch time               (master -> slave)
//   rd_idx    : lap select, 0 = most recent       (master -> slave)
//   rd_data   : registered lap value              (slave -> master)
//   lap_count : valid entries, saturates at DEPTH (slave -> master)
//   overflow  : sticky, oldest entry overwritten  (slave -> master)
//   reg_busy  : high while the memory is cleared  (slave -> master)
interface lap_store_if #(
  parameter int PTR_W = lap_store_pkg::LAP_PTR_W
);
  logic [stopwatch_pkg::STATE_W-1:0] state;
  logic [stopwatch_pkg::TIME_W-1:0]  time_now;
  logic [PTR_W-1:0]                  rd_idx;
  logic [stopwatch_pkg::TIME_W-1:0]  rd_data;
  logic [PTR_W:0]                    lap_count;
  logic                              overflow;
  logic                              reg_busy;

  modport master (
    output state, time_now, rd_idx,
    input  rd_data, lap_count, overflow, reg_busy
  );

  modport slave (
    input  state, time_now, rd_idx,
    output rd_data, lap_count, overflow, reg_busy
  );
endinterface

// File: rtl/lap_ram.sv
// lap_ram
//   DEPTH x WIDTH storage, one synchronous write port and one registered
//   read port (read-before-write on an address collision).
//   clock : system clock
//   we/waddr/wdata : write port
//   raddr/rdata    : read address, data one cycle later
module lap_ram
  import stopwatch_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3,
  parameter int WIDTH = TIME_W
) (
  input  logic             clock,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/lap_store.sv
// lap_store
//   Responds to the stopwatch control FSM: captures a lap timestamp on each
//   entry into RETRIEVE, clears the lap memory on each entry into RESET and
//   raises reg_busy while doing so. Laps are read back newest-first.
//   clock : system clock, all logic on posedge
//   reset : synchronous active-high reset
//   bus   : lap_store_if slave (state, time_now, rd_idx in;
//           rd_data, lap_count, overflow, reg_busy out)
module lap_store
  import stopwatch_pkg::*, lap_store_pkg::*;
#(
  parameter int DEPTH = LAP_DEPTH,
  parameter int PTR_W = LAP_PTR_W
) (
  input  logic       clock,
  input  logic       reset,
  lap_store_if.slave bus
);
  lap_fsm_e         fsm_q, fsm_d;
  logic [PTR_W-1:0] wipe_cnt_q, wipe_cnt_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   lap_count_q, lap_count_d;
  logic             overflow_q, overflow_d;
  logic             rd_zero_q, rd_zero_d;
  // Only the two state bits this block reacts to are remembered.
  logic             prev_reset_q, prev_retrieve_q;

  logic             reset_entry, retrieve_entry;
  logic             wipe_start, capture;

  logic             ram_we;
  logic [PTR_W-1:0] ram_waddr, ram_raddr;
  logic [TIME_W-1:0] ram_wdata, ram_rdata;

  assign reset_entry    = bus.state[RESET]    & ~prev_reset_q;
  assign retrieve_entry = bus.state[RETRIEVE] & ~prev_retrieve_q;
  assign wipe_start     = reset_entry & cmd_legal(bus.state);
  // Capture needs a clean one-hot RETRIEVE; the RESET+RETRIEVE pair wipes.
  assign capture        = retrieve_entry & $onehot(bus.state) & (fsm_q == ST_IDLE);

  always_comb begin
    fsm_d       = fsm_q;
    wipe_cnt_d  = wipe_cnt_q;
    wr_ptr_d    = wr_ptr_q;
    lap_count_d = lap_count_q;
    overflow_d  = overflow_q;
    ram_we      = 1'b0;
    ram_waddr   = wr_ptr_q;
    ram_wdata   = bus.time_now;

    if (fsm_q == ST_WIPE) begin
      ram_we     = 1'b1;
      ram_waddr  = wipe_cnt_q;
      ram_wdata  = '0;
      wipe_cnt_d = wipe_cnt_q + 1'b1;
      if (wipe_cnt_q == PTR_W'(DEPTH - 1)) begin
        fsm_d = ST_IDLE;
      end
    end else if (capture) begin
      ram_we   = 1'b1;
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (lap_count_q == (PTR_W + 1)'(DEPTH)) begin
        overflow_d = 1'b1;
      end else begin
        lap_count_d = lap_count_q + 1'b1;
      end
    end

    // A RESET entry (re)starts the wipe from entry 0, even mid-wipe.
    if (wipe_start) begin
      fsm_d       = ST_WIPE;
      wipe_cnt_d  = '0;
      wr_ptr_d    = '0;
      lap_count_d = '0;
      overflow_d  = 1'b0;
    end
  end

  // Newest lap sits just below the write pointer.
  assign ram_raddr = wr_ptr_q - 1'b1 - bus.rd_idx;
  assign rd_zero_d = ({1'b0, bus.rd_idx} >= lap_count_q) | (fsm_q == ST_WIPE);

  always_ff @(posedge clock) begin
    if (reset) begin
      fsm_q           <= ST_WIPE;
      wipe_cnt_q      <= '0;
      wr_ptr_q        <= '0;
      lap_count_q     <= '0;
      overflow_q      <= 1'b0;
      rd_zero_q       <= 1'b1;
      prev_reset_q    <= 1'b0;
      prev_retrieve_q <= 1'b0;
    end else begin
      fsm_q           <= fsm_d;
      wipe_cnt_q      <= wipe_cnt_d;
      wr_ptr_q        <= wr_ptr_d;
      lap_count_q     <= lap_count_d;
      overflow_q      <= overflow_d;
      rd_zero_q       <= rd_zero_d;
      prev_reset_q    <= bus.state[RESET];
      prev_retrieve_q <= bus.state[RETRIEVE];
    end
  end

  lap_ram #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .WIDTH (TIME_W)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // The RAM output register has no reset; the registered zero flag covers
  // reset, out-of-range indices and reads during a wipe.
  assign bus.rd_data   = rd_zero_q ? '0 : ram_rdata;
  assign bus.lap_count = lap_count_q;
  assign bus.overflow  = overflow_q;
  // The entry cycle itself is busy, so the control FSM cannot leave RESET early.
  assign bus.reg_busy  = (fsm_q == ST_WIPE) | wipe_start;
endmodule

// File: tb/tb_lap_store.sv
// tb_lap_store
//   Randomised and directed stimulus for lap_store. A lap-list reference
//   model produces the expected status each cycle and the expected read data;
//   a separate monitor pops and compares them.
module tb_lap_store;
  localparam int DEPTH = 8;
  localparam logic [10:0] IDLE_V     = 11'h001;
  localparam logic [10:0] RUN_V      = 11'h004;
  localparam logic [10:0] RETRIEVE_V = 11'h020;
  localparam logic [10:0] RESET_V    = 11'h100;
  localparam logic [10:0] BOTH_V     = 11'h120;

  typedef struct packed {
    logic       busy;
    logic [3:0] cnt;
    logic       ovf;
  } status_t;

  typedef struct packed {
    logic [2:0]  idx;
    logic [23:0] val;
  } rd_t;

  logic clk;
  logic reset;
  logic rd_req;
  logic rd_vld;
  logic drain_chk;
  int   total;
  int   bad;

  status_t status_q[$];
  rd_t     rd_exp_q[$];
  status_t mon_s;
  rd_t     mon_r;

  // Reference model: list of recorded laps, newest first.
  logic [23:0] laps[$];
  logic        m_ovf;
  int          m_busy_left;
  logic [10:0] m_prev;

  lap_store_if #(.PTR_W(3)) bus ();

  lap_store #(.DEPTH(DEPTH), .PTR_W(3)) dut (
    .clock (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial rd_vld = 1'b0;
  always @(posedge clk) rd_vld <= rd_req;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  // Monitor: status every modelled cycle, read data whenever a read result is presented.
  always @(negedge clk) begin
    if (status_q.size() > 0) begin
      mon_s = status_q.pop_front();
      check("reg_busy",  32'(bus.reg_busy),  32'(mon_s.busy));
      check("lap_count", 32'(bus.lap_count), 32'(mon_s.cnt));
      check("overflow",  32'(bus.overflow),  32'(mon_s.ovf));
    end
    if (rd_vld) begin
      if (rd_exp_q.size() == 0) begin
        check("rd_underflow", 32'(1), 32'(0));
      end else begin
        mon_r = rd_exp_q.pop_front();
        $display("read idx=%0d data=%06h expect=%06h", mon_r.idx, bus.rd_data, mon_r.val);
        check("rd_data", 32'(bus.rd_data), 32'(mon_r.val));
      end
    end
    if (drain_chk) begin
      check("rd_queue_empty", 32'(rd_exp_q.size()), 32'(0));
    end
  end

  task automatic model_reset();
    laps.delete();
    m_ovf       = 1'b0;
    m_busy_left = DEPTH;
    m_prev      = '0;
  endtask

  // Apply one cycle of stimulus, record expectations, advance the model.
  task automatic cycle(input logic [10:0] st, input logic [23:0] tn,
                       input logic rq, input logic [2:0] idx);
    logic [10:0] entry;
    logic        onehot;
    logic        wstart;
    status_t     s;
    rd_t         r;
    bus.state    = st;
    bus.time_now = tn;
    bus.rd_idx   = idx;
    rd_req       = rq;
    entry  = st & ~m_prev;
    onehot = ($countones(st) == 1);
    wstart = entry[8] && (onehot || st == BOTH_V);
    s.busy = (m_busy_left > 0) || wstart;
    s.cnt  = 4'(laps.size());
    s.ovf  = m_ovf;
    status_q.push_back(s);
    if (rq) begin
      r.idx = idx;
      r.val = (m_busy_left > 0 || int'(idx) >= laps.size()) ? 24'h0 : laps[idx];
      rd_exp_q.push_back(r);
    end
    if (wstart) begin
      laps.delete();
      m_ovf       = 1'b0;
      m_busy_left = DEPTH;
    end else if (m_busy_left > 0) begin
      m_busy_left--;
    end else if (onehot && entry[5]) begin
      laps.push_front(tn);
      if (laps.size() > DEPTH) begin
        void'(laps.pop_back());
        m_ovf = 1'b1;
      end
    end
    m_prev = st;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [23:0] vals [3];
    logic [10:0] st;
    int          r;
    total     = 0;
    bad       = 0;
    drain_chk = 1'b0;
    reset     = 1'b1;
    rd_req    = 1'b0;
    bus.state    = IDLE_V;
    bus.time_now = '0;
    bus.rd_idx   = '0;
    vals[0] = 24'h000105;
    vals[1] = 24'h000230;
    vals[2] = 24'h010000;

    // One-cycle reset pulse, then the post-reset wipe.
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 12; i++) cycle(IDLE_V, 24'(i), 1'b1, 3'(i));

    // Three captures.
    for (int i = 0; i < 3; i++) begin
      cycle(RETRIEVE_V, vals[i], 1'b0, 3'd0);
      cycle(RUN_V, vals[i] + 24'h1, 1'b0, 3'd0);
    end
    for (int i = 0; i < 8; i++) cycle(RUN_V, 24'h0, 1'b1, 3'(i));

    // Holding RETRIEVE captures once.
    for (int i = 0; i < 5; i++) cycle(RETRIEVE_V, 24'h000500 + 24'(i), 1'b1, 3'd0);
    cycle(RUN_V, 24'h0, 1'b1, 3'd0);

    // Wipe, then nine captures to overflow.
    cycle(RESET_V, 24'h0, 1'b1, 3'd0);
    for (int i = 0; i < 10; i++) cycle(IDLE_V, 24'h0, 1'b1, 3'(i));
    for (int v = 1; v <= 9; v++) begin
      cycle(RETRIEVE_V, 24'(v), 1'b0, 3'd0);
      cycle(RUN_V, 24'h0, 1'b0, 3'd0);
    end
    for (int i = 0; i < 8; i++) cycle(RUN_V, 24'h0, 1'b1, 3'(i));

    // RESET and RETRIEVE entered together: wipe wins.
    cycle(BOTH_V, 24'hABCDEF, 1'b1, 3'd0);
    for (int i = 0; i < 11; i++) cycle(IDLE_V, 24'h0, 1'b1, 3'd0);

    // Non-one-hot vectors change nothing.
    cycle(RETRIEVE_V, 24'h123456, 1'b0, 3'd0);
    cycle(RUN_V, 24'h0, 1'b0, 3'd0);
    for (int i = 0; i < 4; i++) cycle(11'h000, 24'h111111, 1'b1, 3'd0);
    for (int i = 0; i < 4; i++) cycle(11'h003, 24'h222222, 1'b1, 3'd1);

    // Randomised traffic.
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 1)       st = RESET_V;
      else if (r < 2)  st = BOTH_V;
      else if (r < 35) st = RETRIEVE_V;
      else if (r < 38) st = 11'h000;
      else if (r < 41) st = 11'($urandom);
      else             st = 11'(1) << $urandom_range(0, 10);
      cycle(st, 24'($urandom), 1'($urandom), 3'($urandom));
    end

    cycle(IDLE_V, 24'h0, 1'b0, 3'd0);
    cycle(IDLE_V, 24'h0, 1'b0, 3'd0);
    drain_chk = 1'b1;
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
